mk14_mem_arbiter: RTL and testbench
===================================

# mk14_mem_arbiter

Single-port arbiter and display-refresh sequencer for the MK14 program/data BRAM. It sits between the core, the display scan logic and the one shared `bram_sdp` instance, so the core and the display refresh can both run without gating the core. The core gets priority. The display scan gets a guaranteed slot after a bounded wait. Every `REFRESH_DIV` idle cycles the block reads `DISP_LEN` bytes from `DISP_BASE` into a display shadow register.

## Interface
Clocking and reset (already decided): one clock, `clk`; reset `rst` is asynchronous and active-high.

Parameters:
- `DISP_BASE`, default 16'h0D00: first display byte address.
- `DISP_LEN`, default 8: number of display bytes. Range 1..8.
- `STARVE_MAX`, default 16: maximum number of consecutive cycles the scan may lose to the core. Must be ≥1.
- `REFRESH_DIV`, default 1024: idle cycles between frames. Must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `core_req`  in  1  core requests a memory access this cycle.
- `core_addr`  in  16  core address.
- `core_we`  in  1  core write enable; qualified by `core_gnt`.
- `core_wdata`  in  8  core write data.
- `core_gnt`  out  1  combinational; the core access is issued to the BRAM this cycle.
- `core_rvalid`  out  1  registered; `core_rdata` is valid this cycle.
- `core_rdata`  out  8  equals `bram_rdata` (pass-through).
- `bram_addr`  out  16  BRAM address, driven combinationally from the selected requester.
- `bram_we`  out  1  BRAM write enable.
- `bram_wdata`  out  8  BRAM write data.
- `bram_rdata`  in  8  BRAM read data; 1-cycle latency.
- `display`  out  64  shadow register; byte i is `display[8*i+7 -: 8]`.
- `frame_done`  out  1  one-cycle pulse after the last display byte is captured.

## Operation
Scan FSM states:
- `S_IDLE`
  - The refresh timer counts 0..REFRESH_DIV-1.
  - At terminal count: go to `S_SCAN`, set `idx`=0, set `wait_cnt`=0.
- `S_SCAN`
  - The scan wants a slot (`scan_want`=1).
  - On a display grant: `bram_addr`=DISP_BASE+idx, `bram_we`=0, `idx`++.
  - When the grant issues the read for idx=DISP_LEN-1: go to `S_DRAIN`.
- `S_DRAIN`
  - Capture the last byte and pulse `frame_done`.
  - Go to `S_IDLE`; the timer restarts at 0.

Capture rule: a display read issued in cycle t is written into display byte `idx_t` at the edge ending cycle t+1. `cap_valid` and `cap_idx` are the registered copies of the grant and index. Issue and capture overlap, so back-to-back grants scan one byte per cycle.

Arbitration, evaluated every cycle:
- `scan_want`=0: the core gets the slot if `core_req`.
- `scan_want`=1 and `core_req`=0: the display gets the slot.
- `scan_want`=1 and `core_req`=1: the core wins while `wait_cnt`<STARVE_MAX, and `wait_cnt` increments. Otherwise the display wins and `core_gnt`=0.
- `wait_cnt` clears on every display grant.
- A core that is denied holds `core_req`, `core_addr`, `core_we` and `core_wdata` stable until granted.

`core_rvalid` is asserted exactly one cycle after a cycle with `core_gnt`=1 and `core_we`=0. It is never asserted for writes.

Core writes into the display region are not snooped. They appear on `display` at the next frame only if they land before that byte's read is issued.

Arithmetic widths:
- `idx` and `cap_idx`: 3 bits.
- `wait_cnt`: $clog2(STARVE_MAX+1) bits, saturating.
- Refresh timer: $clog2(REFRESH_DIV) bits, minimum 1.
- `DISP_BASE+idx` is 16-bit and wraps modulo 2^16.

## Timing
Reset values:
- State `S_IDLE`; timer, `idx`, `wait_cnt` and `cap_valid` all 0.
- Outputs: `display`=0, `frame_done`=0, `core_rvalid`=0.
- `core_gnt` follows `core_req` while idle.

Latency:
- Core read data: 1 cycle after grant.
- Uncontended frame: DISP_LEN+1 cycles from entering `S_SCAN` to `frame_done`.
- Core stall bound: a continuously requesting core loses at most 1 cycle per STARVE_MAX+1 while a scan is active.

Reset asserted mid-scan:
- Asynchronous return to the reset values above.
- Partial display bytes are cleared, and no `frame_done` is issued.

Simultaneous events:
- A display grant and a capture for a different idx in the same cycle are both performed.
- The timer does not count outside `S_IDLE`; no refresh requests are queued or lost.

## Structure
- Package `mk14_pkg`:
  - `scan_state_t` enum (`S_IDLE`, `S_SCAN`, `S_DRAIN`).
  - Localparam `DISP_BASE_DEFAULT`=16'h0D00.
- No sub-module. The refresh timer, scan FSM and arbiter are small and tightly coupled through `scan_want`.
- The BRAM stays outside this block; `mk14_soc` connects `bram_*` to `bram_sdp` with `addr_read`=`addr_write`=`bram_addr`.

## Test plan
- Preload 0x0D00..0x0D07 with 11..88h, hold `core_req`=0, use REFRESH_DIV=4 → `frame_done` pulses 13 cycles after reset release and `display`=64'h8877665544332211.
- Hold `core_req`=1 continuously, STARVE_MAX=2, during a scan → the core is denied exactly every 3rd cycle and the frame completes in 3*8 cycles.
- Core write 5Ah to 0x0D03 and read it back → `core_rvalid` one cycle after the read grant with `core_rdata`=5Ah; the next frame shows byte 3 = 5Ah.
- Assert `rst` while idx=4 → `display`=0 and `frame_done` stays 0; the first frame after release completes normally.
- Core read granted on the cycle the timer expires → the core read completes, the scan starts the next cycle, and there is no spurious `core_rvalid` for display reads.

Source files
------------

// File: rtl/mk14_mem_arbiter_pkg.sv
// mk14_pkg: shared types and constants for the MK14 memory arbiter.
// Holds the display scan state encoding and the default display base
// address so the arbiter and anything instantiating it agree on them.
package mk14_pkg;

  // Display refresh sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } scan_state_t;

  // First byte of the MK14 display segment image in program/data memory
  localparam logic [15:0] DISP_BASE_DEFAULT = 16'h0D00;

endpackage

// File: rtl/mk14_mem_arbiter_if.sv
// mk14_mem_arbiter_if: bundles the core request channel, the shared BRAM
// port and the display shadow outputs of the MK14 memory arbiter.
//   core_req/core_addr/core_we/core_wdata : core access request
//   core_gnt/core_rvalid/core_rdata       : core grant and read return
//   bram_addr/bram_we/bram_wdata          : BRAM command (arbiter drives)
//   bram_rdata                            : BRAM read data, 1-cycle latency
//   display/frame_done                    : display shadow and frame pulse
// Modport slave is the arbiter's view; master is the surrounding system
// (core, BRAM and display consumer) as seen from outside.
interface mk14_mem_arbiter_if;
  logic        core_req;
  logic [15:0] core_addr;
  logic        core_we;
  logic [7:0]  core_wdata;
  logic        core_gnt;
  logic        core_rvalid;
  logic [7:0]  core_rdata;
  logic [15:0] bram_addr;
  logic        bram_we;
  logic [7:0]  bram_wdata;
  logic [7:0]  bram_rdata;
  logic [63:0] display;
  logic        frame_done;

  modport slave (
    input  core_req, core_addr, core_we, core_wdata, bram_rdata,
    output core_gnt, core_rvalid, core_rdata,
    output bram_addr, bram_we, bram_wdata, display, frame_done
  );

  modport master (
    output core_req, core_addr, core_we, core_wdata, bram_rdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  bram_addr, bram_we, bram_wdata, display, frame_done
  );
endinterface

// File: rtl/mk14_mem_arbiter.sv
// mk14_mem_arbiter: shares one BRAM port between the MK14 core and a
// display refresh sequencer. The core normally has priority; the scan gets
// a slot after at most STARVE_MAX lost cycles. Every REFRESH_DIV idle
// cycles DISP_LEN bytes from DISP_BASE are copied into the display shadow.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : mk14_mem_arbiter_if.slave (core channel, BRAM port, display)
module mk14_mem_arbiter
  import mk14_pkg::*;
#(
  parameter logic [15:0] DISP_BASE   = DISP_BASE_DEFAULT,
  parameter int          DISP_LEN    = 8,
  parameter int          STARVE_MAX  = 16,
  parameter int          REFRESH_DIV = 1024
) (
  input logic                clk,
  input logic                rst,
  mk14_mem_arbiter_if.slave  bus
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int WW = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [WW-1:0] WAIT_LIM   = WW'(STARVE_MAX);
  localparam logic [2:0]    IDX_LAST   = 3'(DISP_LEN - 1);

  scan_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          cap_valid_q;
  logic [2:0]    cap_idx_q;
  logic [63:0]   display_q;
  logic          frame_done_q;
  logic          core_rvalid_q;

  logic scan_want;
  logic disp_gnt;
  logic core_gnt;

  // Slot arbitration. The scan only takes the slot from a requesting core
  // once the core has won STARVE_MAX consecutive contested cycles.
  always_comb begin
    scan_want = (state_q == S_SCAN);
    disp_gnt  = scan_want && (!bus.core_req || (wait_cnt_q >= WAIT_LIM));
    core_gnt  = bus.core_req && !disp_gnt;
  end

  // Scan sequencer next state. The refresh timer only runs while idle, so a
  // long contested scan simply delays the next frame instead of queueing it.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (timer_q == TIMER_LAST) begin
          state_d    = S_SCAN;
          timer_d    = '0;
          idx_d      = '0;
          wait_cnt_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SCAN: begin
        if (disp_gnt) begin
          idx_d      = idx_q + 3'd1;
          wait_cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DRAIN;
          end
        end else if (bus.core_req) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Read return path. A display read issued in cycle t is captured at the
  // end of t+1 using the registered index, which lets the next grant issue
  // while the previous byte is still landing. frame_done fires the cycle
  // after DRAIN, once the final byte is already in the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_valid_q   <= 1'b0;
      cap_idx_q     <= '0;
      display_q     <= '0;
      frame_done_q  <= 1'b0;
      core_rvalid_q <= 1'b0;
    end else begin
      cap_valid_q   <= disp_gnt;
      cap_idx_q     <= idx_q;
      frame_done_q  <= (state_q == S_DRAIN);
      core_rvalid_q <= core_gnt && !bus.core_we;
      if (cap_valid_q) begin
        display_q[{cap_idx_q, 3'b000} +: 8] <= bus.bram_rdata;
      end
    end
  end

  // BRAM command mux and output wiring
  always_comb begin
    bus.core_gnt    = core_gnt;
    bus.core_rvalid = core_rvalid_q;
    bus.core_rdata  = bus.bram_rdata;
    bus.bram_addr   = disp_gnt ? (DISP_BASE + {13'd0, idx_q}) : bus.core_addr;
    bus.bram_we     = core_gnt && bus.core_we;
    bus.bram_wdata  = bus.core_wdata;
    bus.display     = display_q;
    bus.frame_done  = frame_done_q;
  end

endmodule

// File: tb/tb_mk14_mem_arbiter.sv
// tb_mk14_mem_arbiter: randomized scoreboard bench for mk14_mem_arbiter.
// A transaction-level model of the arbitration rules predicts grants, read
// data and display frames; a separate monitor pops the expectations when
// the DUT presents core_rvalid or frame_done.
module tb_mk14_mem_arbiter;
  import mk14_pkg::*;

  localparam logic [15:0] DISP_BASE   = DISP_BASE_DEFAULT;
  localparam int          DISP_LEN    = 8;
  localparam int          STARVE_MAX  = 2;
  localparam int          REFRESH_DIV = 4;

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycleNo = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mk14_mem_arbiter_if bus();

  mk14_mem_arbiter #(
    .DISP_BASE   (DISP_BASE),
    .DISP_LEN    (DISP_LEN),
    .STARVE_MAX  (STARVE_MAX),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Cycle index used to time-stamp expectations
  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Behavioural BRAM: read-first, one cycle read latency
  logic [7:0] mem    [0:65535];
  logic [7:0] refMem [0:65535];
  logic [7:0] bramRdata;
  assign bus.bram_rdata = bramRdata;

  always @(posedge clk) begin
    bramRdata <= mem[bus.bram_addr];
    if (bus.bram_we) mem[bus.bram_addr] = bus.bram_wdata;
  end

  // Scoreboard queues and reference model state
  expT rdQ[$];
  expT frameQ[$];

  bit          mIdle;
  bit          mDrain;
  int          idleCount;
  int          bytesDone;
  int          lostStreak;
  logic [63:0] expDisplay;

  bit          pending;
  logic [15:0] pAddr;
  bit          pWe;
  logic [7:0]  pWd;
  bit          lastGnt;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic resetModel();
    mIdle      = 1'b1;
    mDrain     = 1'b0;
    idleCount  = 0;
    bytesDone  = 0;
    lostStreak = 0;
    expDisplay = '0;
    pending    = 1'b0;
    rdQ.delete();
    frameQ.delete();
  endtask

  // One bus cycle: present the (held) core request, then predict the slot
  // owner from the rules: idle -> core; scanning -> core unless it has
  // already won STARVE_MAX contested cycles in a row.
  task automatic applyStimulus(input bit wantReq, input logic [15:0] addr,
                               input bit we, input logic [7:0] wd);
    bit expGnt;
    int c;
    @(negedge clk);
    if (!pending && wantReq) begin
      pending = 1'b1;
      pAddr   = addr;
      pWe     = we;
      pWd     = wd;
    end
    bus.core_req   = pending;
    bus.core_addr  = pAddr;
    bus.core_we    = pWe;
    bus.core_wdata = pWd;
    #1;
    c      = cycleNo;
    expGnt = 1'b0;
    if (mIdle) begin
      expGnt = pending;
      idleCount++;
      if (idleCount == REFRESH_DIV) begin
        mIdle      = 1'b0;
        bytesDone  = 0;
        lostStreak = 0;
      end
    end else if (mDrain) begin
      expGnt    = pending;
      mDrain    = 1'b0;
      mIdle     = 1'b1;
      idleCount = 0;
    end else begin
      if (pending && lostStreak < STARVE_MAX) begin
        expGnt = 1'b1;
        lostStreak++;
      end else begin
        expDisplay[8*bytesDone +: 8] = refMem[16'(DISP_BASE + bytesDone)];
        bytesDone++;
        lostStreak = 0;
        if (bytesDone == DISP_LEN) begin
          mDrain = 1'b1;
          frameQ.push_back('{c + 2, expDisplay});
        end
      end
    end
    checkOutput("core_gnt", 64'(bus.core_gnt), 64'(expGnt));
    if (expGnt) begin
      if (pWe) refMem[pAddr] = pWd;
      else     rdQ.push_back('{c + 1, 64'(refMem[pAddr])});
      pending = 1'b0;
    end
    lastGnt = expGnt;
  endtask

  task automatic issueAndWait(input logic [15:0] addr, input bit we, input logic [7:0] wd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      applyStimulus(1'b1, addr, we, wd);
      done = lastGnt;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL issue_timeout: addr %0h not granted within 60 cycles", addr);
    end
  endtask

  task automatic waitFrames(input int n, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 8'h0);
      if (bus.frame_done) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: saw %0d frame_done pulses, required %0d", name, seen, n);
    end
  endtask

  function automatic logic [15:0] randAddr();
    if ($urandom_range(0, 1) == 0) return 16'(DISP_BASE + 16'($urandom_range(0, 15)));
    return 16'($urandom);
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a read return or
  // a finished frame, and flags returns that never arrive.
  always @(negedge clk) begin : monitor
    expT e;
    if (!rst) begin
      if (bus.core_rvalid) begin
        if (rdQ.size() == 0) begin
          checkOutput("rvalid_spurious", 64'(bus.core_rvalid), 64'd0);
        end else begin
          e = rdQ.pop_front();
          checkOutput("core_rdata", 64'(bus.core_rdata), e.val);
          checkOutput("rvalid_cycle", 64'(cycleNo), 64'(e.cyc));
        end
      end else if (rdQ.size() > 0 && rdQ[0].cyc <= cycleNo) begin
        e = rdQ.pop_front();
        checkOutput("rvalid_missing", 64'(bus.core_rvalid), 64'd1);
      end
      if (bus.frame_done) begin
        if (frameQ.size() == 0) begin
          checkOutput("frame_done_spurious", 64'(bus.frame_done), 64'd0);
        end else begin
          e = frameQ.pop_front();
          checkOutput("display", bus.display, e.val);
          checkOutput("frame_done_cycle", 64'(cycleNo), 64'(e.cyc));
        end
      end else if (frameQ.size() > 0 && frameQ[0].cyc <= cycleNo) begin
        e = frameQ.pop_front();
        checkOutput("frame_done_missing", 64'(bus.frame_done), 64'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    bit hit;
    bus.core_req   = 1'b0;
    bus.core_addr  = 16'h0;
    bus.core_we    = 1'b0;
    bus.core_wdata = 8'h0;
    pAddr = 16'h0;
    pWe   = 1'b0;
    pWd   = 8'h0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = 8'(i) ^ 8'(i >> 8) ^ 8'h5C;
      refMem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5C;
    end
    for (int i = 0; i < 8; i++) begin
      mem[16'(DISP_BASE + i)]    = 8'(8'h11 * (i + 1));
      refMem[16'(DISP_BASE + i)] = 8'(8'h11 * (i + 1));
    end
    resetModel();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_display", bus.display, 64'd0);
    checkOutput("rst_frame_done", 64'(bus.frame_done), 64'd0);
    checkOutput("rst_rvalid", 64'(bus.core_rvalid), 64'd0);
    #1 rst = 1'b0;

    // Idle core: first frame 13 cycles after release with the preloaded bytes
    $display("[TB] phase: uncontended first frame");
    k = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 8'h0);
      if (bus.frame_done) hit = 1'b1;
      else k++;
    end
    checkOutput("first_frame_latency", 64'(k), 64'd13);
    checkOutput("first_frame_display", bus.display, 64'h8877665544332211);

    // Continuously requesting core across scans
    $display("[TB] phase: continuous core reads");
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, randAddr(), 1'b0, 8'h0);

    // Write 5Ah into display byte 3 and read it back
    $display("[TB] phase: display write and readback");
    issueAndWait(16'(DISP_BASE + 3), 1'b1, 8'h5A);
    issueAndWait(16'(DISP_BASE + 3), 1'b0, 8'h00);
    waitFrames(2, "frame_after_write");
    checkOutput("display_byte3", 64'(bus.display[31:24]), 64'h5A);

    // Random mixed traffic
    $display("[TB] phase: random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, randAddr(), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset while the scan is at idx 4
    $display("[TB] phase: reset mid-scan");
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      applyStimulus($urandom_range(0, 99) < 40, randAddr(), 1'($urandom_range(0, 1)), 8'($urandom));
      if (!mIdle && !mDrain && bytesDone == 4) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL midscan_search: idx 4 not reached");
    end
    @(negedge clk);
    bus.core_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("midscan_rst_display", bus.display, 64'd0);
    checkOutput("midscan_rst_frame_done", 64'(bus.frame_done), 64'd0);
    checkOutput("midscan_rst_rvalid", 64'(bus.core_rvalid), 64'd0);
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midscan_rst_hold_frame_done", 64'(bus.frame_done), 64'd0);
    #1 rst = 1'b0;
    waitFrames(1, "frame_after_reset");

    // More random traffic, then let everything drain
    $display("[TB] phase: random traffic 2");
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 99) < 80, randAddr(), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 8'h0);
      if (!pending && mIdle && rdQ.size() == 0 && frameQ.size() == 0) hit = 1'b1;
    end
    checkOutput("rdq_drained", 64'(rdQ.size()), 64'd0);
    checkOutput("frameq_drained", 64'(frameQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
